// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: conditions raw push-button/switch pads for the MCU high
// GPIO inputs. Each channel is synchronised, debounced by a stability
// counter and reported as a clean level plus one-cycle rise/fall pulses.
// Rejected glitches from all channels feed one shared saturating counter.
module gpio_in_debounce #(
    parameter int   NUM_CH          = 4,
    parameter int   CNT_W           = 16,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   SYNC_STAGES     = 2,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pad_in,
    output logic [NUM_CH-1:0] gpio_h_in,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    input  logic              glitch_clr,
    output logic [7:0]        glitch_cnt
);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_e;

    // Counter value on the cycle the new level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_s;

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] glitch_flag;

    logic [7:0]        glitch_cnt_q, glitch_cnt_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; stage 0 samples the asynchronous pads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {NUM_CH{IDLE_LEVEL}};
            end
        end else begin
            sync_q[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Per-channel debounce FSM: count consecutive cycles where the
    // synchronised pad differs from the accepted level, accept after a full
    // run, and flag a glitch if the pad returns before the run completes.
    always_comb begin
        level_d     = level_q;
        rise_d      = '0;
        fall_d      = '0;
        glitch_flag = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            case (state_q[ch])
                STABLE: begin
                    if (sync_s[ch] != level_q[ch]) begin
                        state_d[ch] = COUNTING;
                        cnt_d[ch]   = CNT_W'(1);
                    end else begin
                        cnt_d[ch]   = '0;
                    end
                end
                COUNTING: begin
                    if (sync_s[ch] == level_q[ch]) begin
                        state_d[ch]     = STABLE;
                        cnt_d[ch]       = '0;
                        glitch_flag[ch] = 1'b1;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        level_d[ch] = sync_s[ch];
                        rise_d[ch]  = sync_s[ch];
                        fall_d[ch]  = ~sync_s[ch];
                        state_d[ch] = STABLE;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch]   = cnt_q[ch] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[ch] = STABLE;
                    cnt_d[ch]   = '0;
                end
            endcase
        end
    end

    // Shared glitch counter: one step per cycle with any glitch, saturating
    // at 255; a clear request overrides a simultaneous glitch.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if ((|glitch_flag) && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    // State registers; reset returns every channel to the idle level
    // without producing any pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= STABLE;
                cnt_q[ch]   <= '0;
            end
            level_q      <= {NUM_CH{IDLE_LEVEL}};
            rise_q       <= '0;
            fall_q       <= '0;
            glitch_cnt_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign gpio_h_in  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Testbench for gpio_in_debounce: directed scenarios plus randomized pad
// activity, every cycle compared against a history-window reference model.
module tb_gpio_in_debounce;

    localparam int   NUM_CH = 4;
    localparam int   CNT_W  = 16;
    localparam int   DC     = 8;
    localparam int   SYNC   = 2;
    localparam logic IDLE   = 1'b1;

    logic              clk = 1'b0;
    logic              rst;
    logic              glitch_clr;
    logic [NUM_CH-1:0] pad_in;
    logic [NUM_CH-1:0] gpio_h_in;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic [7:0]        glitch_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted level flips when the last DC synchronised
    // samples all differ from it; a glitch is a return to the accepted
    // level right after a differing sample.
    logic [NUM_CH-1:0] mLevel, mRise, mFall;
    logic [7:0]        mGcnt;
    logic [NUM_CH-1:0] padQ[$];
    logic [NUM_CH-1:0] seenQ[$];

    logic [NUM_CH-1:0] pulseAcc;
    int                riseCnt [NUM_CH];
    int                fallCnt [NUM_CH];

    always #5 clk = ~clk;

    gpio_in_debounce #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES(SYNC),
        .IDLE_LEVEL(IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pad_in(pad_in),
        .gpio_h_in(gpio_h_in),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .glitch_clr(glitch_clr),
        .glitch_cnt(glitch_cnt)
    );

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Model state after a reset edge.
    task automatic modelReset();
        padQ.delete();
        seenQ.delete();
        for (int i = 0; i < SYNC; i++) padQ.push_back({NUM_CH{IDLE}});
        for (int i = 0; i < DC; i++) seenQ.push_back({NUM_CH{IDLE}});
        mLevel = {NUM_CH{IDLE}};
        mRise  = '0;
        mFall  = '0;
        mGcnt  = '0;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic modelEdge();
        logic [NUM_CH-1:0] seen, prevSeen, v;
        logic              glitch, allDiff;
        if (rst) begin
            modelReset();
        end else begin
            seen = padQ.pop_front();
            padQ.push_back(pad_in);
            prevSeen = seenQ[DC-1];
            void'(seenQ.pop_front());
            seenQ.push_back(seen);
            glitch = 1'b0;
            mRise  = '0;
            mFall  = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                allDiff = 1'b1;
                for (int k = 0; k < DC; k++) begin
                    v = seenQ[k];
                    if (v[ch] == mLevel[ch]) allDiff = 1'b0;
                end
                if (seen[ch] == mLevel[ch] && prevSeen[ch] != mLevel[ch]) begin
                    glitch = 1'b1;
                end else if (allDiff) begin
                    mLevel[ch] = seen[ch];
                    if (seen[ch]) mRise[ch] = 1'b1;
                    else          mFall[ch] = 1'b1;
                end
            end
            if (glitch_clr)                  mGcnt = '0;
            else if (glitch && mGcnt != 255) mGcnt = mGcnt + 8'd1;
        end
    endtask

    // One clock: update the model on the edge, sample the DUT 1 ns later.
    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("gpio_h_in", 32'(gpio_h_in), 32'(mLevel));
        checkOutput("rise_pulse", 32'(rise_pulse), 32'(mRise));
        checkOutput("fall_pulse", 32'(fall_pulse), 32'(mFall));
        checkOutput("glitch_cnt", 32'(glitch_cnt), 32'(mGcnt));
        pulseAcc = pulseAcc | rise_pulse | fall_pulse;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rise_pulse[ch]) riseCnt[ch]++;
            if (fall_pulse[ch]) fallCnt[ch]++;
        end
    endtask

    // Drive inputs and hold them for n clocks.
    task automatic applyStimulus(input logic [NUM_CH-1:0] pad, input logic rstV,
                                 input logic clrV, input int n);
        pad_in     = pad;
        rst        = rstV;
        glitch_clr = clrV;
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until a pulse of the chosen kind appears on a masked channel.
    task automatic waitPulse(input logic [NUM_CH-1:0] mask, input bit fall,
                             input int maxEdges, output int edges);
        edges = -1;
        for (int i = 1; i <= maxEdges; i++) begin
            step();
            if (((fall ? fall_pulse : rise_pulse) & mask) != '0) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic clearTally();
        pulseAcc = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            riseCnt[ch] = 0;
            fallCnt[ch] = 0;
        end
    endtask

    initial begin
        int edges;
        int hold;
        clearTally();
        pad_in     = '0;
        rst        = 1'b1;
        glitch_clr = 1'b0;

        $display("[TB] reset with pads low");
        applyStimulus(4'b0000, 1'b1, 1'b0, 3);
        checkOutput("reset_level", 32'(gpio_h_in), 32'hF);
        checkOutput("reset_pulses", 32'(rise_pulse | fall_pulse), 32'h0);
        checkOutput("reset_gcnt", 32'(glitch_cnt), 32'h0);

        rst = 1'b0;
        waitPulse(4'b1111, 1'b1, 30, edges);
        checkOutput("release_fall_edges", 32'(edges), 32'd10);
        checkOutput("release_fall_vec", 32'(fall_pulse), 32'hF);
        checkOutput("release_level", 32'(gpio_h_in), 32'h0);
        step();
        checkOutput("release_fall_width", 32'(fall_pulse), 32'h0);

        $display("[TB] pads back high");
        pad_in = 4'b1111;
        waitPulse(4'b1111, 1'b0, 30, edges);
        checkOutput("rise_all_edges", 32'(edges), 32'd10);
        checkOutput("rise_all_vec", 32'(rise_pulse), 32'hF);
        applyStimulus(4'b1111, 1'b0, 1'b0, 3);

        $display("[TB] clean press on channel 0");
        pad_in = 4'b1110;
        waitPulse(4'b0001, 1'b1, 30, edges);
        checkOutput("press_edges", 32'(edges), 32'd10);
        checkOutput("press_level", 32'(gpio_h_in), 32'hE);
        checkOutput("press_fall_vec", 32'(fall_pulse), 32'h1);
        step();
        checkOutput("press_fall_width", 32'(fall_pulse), 32'h0);
        pad_in = 4'b1111;
        waitPulse(4'b0001, 1'b0, 30, edges);
        checkOutput("release0_edges", 32'(edges), 32'd10);
        applyStimulus(4'b1111, 1'b0, 1'b1, 1);

        $display("[TB] bounce on channel 1");
        clearTally();
        applyStimulus(4'b1101, 1'b0, 1'b0, 5);
        applyStimulus(4'b1111, 1'b0, 1'b0, 3);
        applyStimulus(4'b1101, 1'b0, 1'b0, 4);
        applyStimulus(4'b1111, 1'b0, 1'b0, 12);
        checkOutput("bounce_level", 32'(gpio_h_in), 32'hF);
        checkOutput("bounce_pulses", 32'(pulseAcc), 32'h0);
        checkOutput("bounce_gcnt", 32'(glitch_cnt), 32'd2);

        $display("[TB] boundary on channel 2");
        clearTally();
        applyStimulus(4'b1011, 1'b0, 1'b0, 7);
        applyStimulus(4'b1111, 1'b0, 1'b0, 12);
        checkOutput("short7_pulses", 32'(pulseAcc), 32'h0);
        applyStimulus(4'b1011, 1'b0, 1'b0, 8);
        applyStimulus(4'b1111, 1'b0, 1'b0, 2);
        checkOutput("exact8_level", 32'(gpio_h_in), 32'hB);
        applyStimulus(4'b1111, 1'b0, 1'b0, 15);
        checkOutput("exact8_falls", 32'(fallCnt[2]), 32'd1);
        checkOutput("exact8_rises", 32'(riseCnt[2]), 32'd1);
        checkOutput("exact8_final", 32'(gpio_h_in), 32'hF);

        $display("[TB] simultaneous glitches on channels 0 and 3");
        applyStimulus(4'b1111, 1'b0, 1'b1, 1);
        applyStimulus(4'b0110, 1'b0, 1'b0, 3);
        applyStimulus(4'b1111, 1'b0, 1'b0, 8);
        checkOutput("simul_gcnt", 32'(glitch_cnt), 32'd1);

        $display("[TB] glitch counter saturation");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'b1110, 1'b0, 1'b0, 2);
            applyStimulus(4'b1111, 1'b0, 1'b0, 2);
        end
        applyStimulus(4'b1111, 1'b0, 1'b0, 4);
        checkOutput("sat_gcnt", 32'(glitch_cnt), 32'd255);

        $display("[TB] clear coinciding with a glitch");
        applyStimulus(4'b1110, 1'b0, 1'b0, 2);
        applyStimulus(4'b1111, 1'b0, 1'b0, 2);
        applyStimulus(4'b1111, 1'b0, 1'b1, 1);
        checkOutput("clr_glitch_gcnt", 32'(glitch_cnt), 32'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0, 4);
        checkOutput("clr_after_gcnt", 32'(glitch_cnt), 32'd0);

        $display("[TB] reset during counting on channel 3");
        clearTally();
        applyStimulus(4'b0111, 1'b0, 1'b0, 7);
        applyStimulus(4'b0111, 1'b1, 1'b0, 2);
        checkOutput("midrst_pulses", 32'(pulseAcc), 32'h0);
        checkOutput("midrst_level", 32'(gpio_h_in), 32'hF);
        rst = 1'b0;
        waitPulse(4'b1000, 1'b1, 30, edges);
        checkOutput("midrst_fall_edges", 32'(edges), 32'd10);
        applyStimulus(4'b1111, 1'b0, 1'b0, 12);

        $display("[TB] randomized pad activity");
        for (int i = 0; i < 300; i++) begin
            hold = $urandom_range(1, 12);
            applyStimulus(4'($urandom), ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 19) == 0), hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
